// File: rtl/ks_pkg.sv
// ks_pkg: shared types and constants for the Karplus-Strong string voice.
// Rev 1.0
`default_nettype none

package ks_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } ks_state_t;

  localparam int          SAMPLE_W  = 8;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [15:0] SEED_DEF  = 16'hACE1;

  // 16-bit Galois LFSR, right shift, taps applied when the bit shifted out is 1.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ks_lfsr16.sv
// ks_lfsr16: 16-bit Galois noise source with seed load and step enable.
// Rev 1.0
`default_nettype none

module ks_lfsr16 #(
  parameter logic [15:0] RESET_VAL = ks_pkg::SEED_DEF
) (
  input  logic        clok,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] seed_val,
  input  logic        step,
  output logic [15:0] state
);
  import ks_pkg::*;

  // Load takes priority so a new pluck always starts from a clean seed.
  always_ff @(posedge clok or negedge rst_n) begin
    if (!rst_n) begin
      state <= RESET_VAL;
    end else if (load) begin
      state <= seed_val;
    end else if (step) begin
      state <= lfsr_next(state);
    end
  end

endmodule

`default_nettype wire

// File: rtl/ks_delay_line.sv
// ks_delay_line: Karplus-Strong circular delay line with LFSR pluck exciter.
// Rev 1.0
`default_nettype none

module ks_delay_line #(
  parameter int          DEPTH    = 512,
  parameter int          AW       = 9,
  parameter int          FB_LAT   = 1,
  parameter logic [15:0] SEED_DEF = ks_pkg::SEED_DEF
) (
  input  logic                         clok,
  input  logic                         rst_n,
  input  logic                         sample_tick,
  input  logic                         pluck,
  input  logic [AW:0]                  period_len,
  input  logic [15:0]                  seed,
  input  logic [ks_pkg::SAMPLE_W-1:0]  fb_in,
  output logic [ks_pkg::SAMPLE_W-1:0]  dl_out,
  output logic                         sample_valid,
  output logic                         busy
);
  import ks_pkg::*;

  localparam logic [AW:0] LEN_MIN = (AW+1)'(2);
  localparam logic [AW:0] LEN_MAX = (AW+1)'(DEPTH);
  localparam int          CW      = (FB_LAT < 2) ? 1 : $clog2(FB_LAT + 1);

  ks_state_t             state, state_nx;
  logic [AW:0]           len_q, len_clamped, last_idx;
  logic [AW-1:0]         wr_addr, rd_ptr, wb_addr;
  logic                  wb_pend;
  logic [CW-1:0]         wb_cnt;
  logic [15:0]           seed_eff, lfsr_state, lfsr_nx;
  logic                  unused_lfsr_hi;
  logic                  wr_last, rd_last;
  logic                  fill_we, tick_run, wb_we, mem_we;
  logic [AW-1:0]         mem_addr;
  logic [SAMPLE_W-1:0]   mem_wdata;
  logic [SAMPLE_W-1:0]   mem [DEPTH];

  always_comb begin
    len_clamped = period_len;
    if (period_len < LEN_MIN) begin
      len_clamped = LEN_MIN;
    end else if (period_len > LEN_MAX) begin
      len_clamped = LEN_MAX;
    end
  end

  assign seed_eff = (seed == 16'h0000) ? SEED_DEF : seed;

  ks_lfsr16 #(
    .RESET_VAL (SEED_DEF)
  ) u_lfsr (
    .clok     (clok),
    .rst_n    (rst_n),
    .load     (pluck),
    .seed_val (seed_eff),
    .step     (fill_we),
    .state    (lfsr_state)
  );

  // The fill writes the value the LFSR is stepping to on this same edge.
  assign lfsr_nx        = lfsr_next(lfsr_state);
  assign unused_lfsr_hi = ^lfsr_nx[15:SAMPLE_W];

  assign last_idx = len_q - (AW+1)'(1);
  assign wr_last  = ({1'b0, wr_addr} == last_idx);
  assign rd_last  = ({1'b0, rd_ptr} == last_idx);

  // A pluck pre-empts fill writes, ticks and any pending write-back.
  assign fill_we  = (state == FILL) && !pluck;
  assign tick_run = (state == RUN) && sample_tick && !pluck;
  assign wb_we    = wb_pend && (wb_cnt == CW'(1)) && !pluck;

  assign mem_we    = fill_we | wb_we;
  assign mem_addr  = fill_we ? wr_addr : wb_addr;
  assign mem_wdata = fill_we ? lfsr_nx[SAMPLE_W-1:0] : fb_in;

  assign busy = (state == FILL);

  always_ff @(posedge clok or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    if (pluck) begin
      state_nx = FILL;
    end else begin
      case (state)
        FILL:    if (wr_last) state_nx = RUN;
        default: state_nx = state;
      endcase
    end
  end

  always_ff @(posedge clok or negedge rst_n) begin
    if (!rst_n) begin
      len_q        <= '0;
      wr_addr      <= '0;
      rd_ptr       <= '0;
      dl_out       <= '0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= tick_run;
      if (pluck) begin
        len_q   <= len_clamped;
        wr_addr <= '0;
        dl_out  <= '0;
      end else if (fill_we) begin
        wr_addr <= wr_addr + AW'(1);
        if (wr_last) begin
          rd_ptr <= '0;
        end
      end else if (tick_run) begin
        dl_out <= mem[rd_ptr];
        rd_ptr <= rd_last ? '0 : rd_ptr + AW'(1);
      end
    end
  end

  // Tick spacing guarantees at most one write-back in flight.
  always_ff @(posedge clok or negedge rst_n) begin
    if (!rst_n) begin
      wb_pend <= 1'b0;
      wb_cnt  <= '0;
      wb_addr <= '0;
    end else if (pluck) begin
      wb_pend <= 1'b0;
    end else if (tick_run) begin
      wb_pend <= 1'b1;
      wb_cnt  <= CW'(FB_LAT);
      wb_addr <= rd_ptr;
    end else if (wb_pend) begin
      if (wb_cnt == CW'(1)) begin
        wb_pend <= 1'b0;
      end else begin
        wb_cnt <= wb_cnt - CW'(1);
      end
    end
  end

  always_ff @(posedge clok) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ks_delay_line.sv
// tb_ks_delay_line: directed self-checking bench for ks_delay_line.
// Rev 1.0
`default_nettype none

module tb_ks_delay_line;

  logic        clok = 1'b0;
  logic        rst_n = 1'b0;
  logic        sample_tick = 1'b0;
  logic        pluck = 1'b0;
  logic [9:0]  period_len = '0;
  logic [15:0] seed = '0;
  logic [7:0]  fb_in = '0;
  logic [7:0]  dl_out;
  logic        sample_valid;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  // First four LFSR bytes from seed 0xACE1, worked by hand.
  logic [7:0] lfsr4 [4];

  ks_delay_line dut (
    .clok         (clok),
    .rst_n        (rst_n),
    .sample_tick  (sample_tick),
    .pluck        (pluck),
    .period_len   (period_len),
    .seed         (seed),
    .fb_in        (fb_in),
    .dl_out       (dl_out),
    .sample_valid (sample_valid),
    .busy         (busy)
  );

  always #5 clok = ~clok;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clok);
    #1;
  endtask

  task automatic do_pluck(input logic [9:0] len, input logic [15:0] sd);
    period_len = len;
    seed       = sd;
    pluck      = 1'b1;
    step();
    pluck      = 1'b0;
  endtask

  // Counts clocks with busy high, starting at the current sample point.
  task automatic fill_wait(input string tag, input int exp);
    int cnt = 0;
    while (busy === 1'b1 && cnt < 2000) begin
      cnt++;
      step();
    end
    check(tag, 32'(cnt), 32'(exp));
  endtask

  // One tick, feedback held across the write-back edge, four clocks total.
  task automatic do_tick(input string tag, input logic [7:0] fb, output logic [7:0] got);
    fb_in       = fb;
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    got = dl_out;
    check({tag, "_sv"}, 32'(sample_valid), 32'd1);
    step();
    step();
    step();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] v;
    lfsr4 = '{8'h70, 8'h38, 8'h9C, 8'h4E};

    step();
    step();
    check("rst_dl", 32'(dl_out), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_sv", 32'(sample_valid), 32'h0);
    rst_n = 1'b1;
    step();

    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    check("idle_sv", 32'(sample_valid), 32'h0);
    check("idle_dl", 32'(dl_out), 32'h0);

    // Length 4: noise burst, then loop closure with fb 0x55, then period check.
    do_pluck(10'd4, 16'hACE1);
    check("fill_dl", 32'(dl_out), 32'h0);
    fill_wait("busy_len4", 4);
    for (int k = 0; k < 4; k++) begin
      do_tick($sformatf("noise_t%0d", k + 1), 8'h55, v);
      check($sformatf("noise_t%0d", k + 1), 32'(v), 32'(lfsr4[k]));
    end
    for (int k = 0; k < 4; k++) begin
      do_tick($sformatf("loop_t%0d", k + 5), 8'(16 + k), v);
      check($sformatf("loop_t%0d", k + 5), 32'(v), 32'h55);
    end
    for (int k = 0; k < 4; k++) begin
      do_tick($sformatf("wrap_t%0d", k + 9), 8'h55, v);
      check($sformatf("wrap_t%0d", k + 9), 32'(v), 32'(16 + k));
    end
    check("sv_pulse", 32'(sample_valid), 32'h0);

    // Asynchronous reset between ticks, right after a valid pulse.
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_dl", 32'(dl_out), 32'h0);
    check("arst_busy", 32'(busy), 32'h0);
    check("arst_sv", 32'(sample_valid), 32'h0);
    step();
    rst_n = 1'b1;
    step();
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    check("post_rst_sv", 32'(sample_valid), 32'h0);
    check("post_rst_dl", 32'(dl_out), 32'h0);

    // Zero seed falls back to the default seed.
    do_pluck(10'd4, 16'h0000);
    fill_wait("busy_seed0", 4);
    for (int k = 0; k < 4; k++) begin
      do_tick($sformatf("seed0_t%0d", k + 1), 8'h00, v);
      check($sformatf("seed0_t%0d", k + 1), 32'(v), 32'(lfsr4[k]));
    end

    // Length 0 clamps to 2.
    do_pluck(10'd0, 16'hACE1);
    fill_wait("busy_len0", 2);
    do_tick("len2_t1", 8'h11, v);
    check("len2_t1", 32'(v), 32'h70);
    do_tick("len2_t2", 8'h22, v);
    check("len2_t2", 32'(v), 32'h38);
    do_tick("len2_t3", 8'h33, v);
    check("len2_t3", 32'(v), 32'h11);
    do_tick("len2_t4", 8'h44, v);
    check("len2_t4", 32'(v), 32'h22);

    // Length 600 clamps to 512; tick k feeds back k so tick 512+k returns k.
    do_pluck(10'd600, 16'hACE1);
    fill_wait("busy_len600", 512);
    for (int k = 1; k <= 514; k++) begin
      do_tick("big", 8'(k), v);
      if (k == 1)   check("big_t1", 32'(v), 32'h70);
      if (k == 2)   check("big_t2", 32'(v), 32'h38);
      if (k == 513) check("big_t513", 32'(v), 32'h01);
      if (k == 514) check("big_t514", 32'(v), 32'h02);
    end

    // Pluck coincident with a tick: the tick is dropped, fill restarts.
    do_pluck(10'd4, 16'hACE1);
    fill_wait("busy_pre_coll", 4);
    do_tick("pre_coll", 8'h55, v);
    check("pre_coll", 32'(v), 32'h70);
    period_len  = 10'd4;
    seed        = 16'hACE1;
    pluck       = 1'b1;
    sample_tick = 1'b1;
    step();
    pluck       = 1'b0;
    sample_tick = 1'b0;
    check("coll_sv", 32'(sample_valid), 32'h0);
    check("coll_busy", 32'(busy), 32'h1);
    fill_wait("busy_coll", 4);
    do_tick("coll_t1", 8'h55, v);
    check("coll_t1", 32'(v), 32'h70);

    // Pluck on the write-back edge: the write-back must never land.
    fb_in       = 8'hEE;
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    check("wb_tick_dl", 32'(dl_out), 32'h38);
    period_len = 10'd4;
    seed       = 16'hACE1;
    pluck      = 1'b1;
    step();
    pluck      = 1'b0;
    fill_wait("busy_wbcan", 4);
    do_tick("wbcan_t1", 8'h00, v);
    check("wbcan_t1", 32'(v), 32'h70);
    do_tick("wbcan_t2", 8'h00, v);
    check("wbcan_t2", 32'(v), 32'h38);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
